ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction-fetch stage feeding the IF/ID pipeline register. It holds the PC, selects the next PC from the sequential, branch, jump, exception and ERET sources, and runs a req/ready handshake to instruction memory. It presents IF_PC, IF_opcplus4 and IF_instruction through a one-entry output buffer that IF/ID consumes on PCWrite.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded by reset
EXC_VECTOR, 32'h0000_0008, exception/interrupt entry address

Ports:
cpu_clk  in  1  clock
reset  in  1  async, active-high
PCWrite  in  1  hazard-unit enable; 1 = IF/ID samples this edge (consumes the output buffer)
exc_req  in  1  exception/interrupt redirect pulse
eret  in  1  return-from-exception pulse
epc  in  32  ERET target
jump  in  1  jump redirect pulse
jump_target  in  32  jump target
branch_taken  in  1  branch redirect pulse
branch_target  in  32  branch target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  imem_rdata valid this cycle; completes request
imem_rdata  in  32  fetched instruction
IF_PC  out  32  PC of buffered instruction
IF_opcplus4  out  32  IF_PC+4
IF_instruction  out  32  buffered instruction
IF_valid  out  1  output buffer holds a valid instruction (0 = bubble)
pc_misalign  out  1  one-cycle pulse: redirect target had bits[1:0]!=0

Behaviour:
- Reset (async, active-high): state=IDLE, pc=RESET_PC, skid=0, pending=0, all IF_* outputs=0, IF_valid=0, pc_misalign=0. imem_req is 0 while reset is high.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - FULL: response parked in the skid register; imem_req=0.
  - DRAIN: stale request in flight; imem_req=1, address held.
- imem_addr and imem_req are stable from the assertion of a request until imem_ready. The address never changes mid-request.
- Buffer rules:
  - slot_free = !IF_valid || PCWrite.
  - A consume with no new capture clears IF_valid at the edge.
- REQ with imem_ready and slot_free: capture IF_instruction=imem_rdata, IF_PC=pc, IF_opcplus4=pc+4, IF_valid=1; pc<=pc+4; stay in REQ. Back-to-back fetches give one instruction per cycle with zero-wait memory.
- REQ with imem_ready and !slot_free: skid<=imem_rdata, go to FULL.
- FULL with slot_free: move skid into the IF_* outputs (PC = pc), pc<=pc+4, go to REQ.
- Redirect priority: exc_req > eret > jump > branch_taken.
  - Targets: EXC_VECTOR, epc, jump_target, branch_target.
  - A redirect pulse at any edge flushes the buffer: IF_valid=0 and IF_PC/IF_opcplus4/IF_instruction zeroed. This overrides any consume or capture at the same edge.
- Redirect in REQ:
  - With imem_ready the same cycle: data is dropped, pc<=target, stay in REQ.
  - Without imem_ready: pending<=target, go to DRAIN.
- Redirect in FULL: skid dropped, pc<=target, go to REQ.
- Redirect in IDLE: pc<=target.
- DRAIN:
  - A further redirect overwrites pending.
  - On imem_ready: data discarded, pc<=pending (or the new target if a redirect arrives the same cycle), go to REQ.
  - No instruction from a DRAIN response ever reaches IF_valid.
- Misaligned target: target bits[1:0] are forced to 00 on load, and pc_misalign pulses 1 for one cycle (registered) at that edge.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0, no flag).
- Reset mid-request: the request is abandoned immediately; memory must tolerate imem_req dropping.

Test Plan:
- Reset release, imem_ready tied 1, PCWrite=1 -> imem_addr 0,4,8,... on consecutive cycles; IF_PC follows one cycle later with IF_opcplus4=IF_PC+4 and IF_valid=1 from the 2nd edge after IDLE.
- Back-pressure: PCWrite=0 for 3 cycles with ready=1 -> one capture, then FULL, imem_req=0, IF_* stable. On PCWrite=1 the skid instruction appears at IF_PC+4 with no address skipped or duplicated.
- imem_ready delayed 3 cycles and branch_taken to 0x100 in the first wait cycle -> imem_addr held at the old PC until ready, that response is discarded, the next request goes to 0x100, and IF_valid stays 0 throughout.
- Same cycle exc_req + jump(0x200) + branch(0x300) -> pc=EXC_VECTOR. Separately, eret with epc=0x44 -> next imem_addr=0x44.
- jump_target=0x103 -> next imem_addr=0x100, pc_misalign high exactly one cycle.
- pc=32'hFFFF_FFFC fetched -> IF_opcplus4=0, next imem_addr=0. Reset asserted mid-wait -> imem_req drops asynchronously, and after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC select with redirect priority, imem req/ready handshake,
// skid register for back-pressure and a one-entry output buffer toward IF/ID.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
    input  logic                 cpu_clk,
    input  logic                 reset,
    input  logic                 PCWrite,
    input  logic                 exc_req,
    input  logic                 eret,
    input  logic [31:0]          epc,
    input  logic                 jump,
    input  logic [31:0]          jump_target,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    ifetch_unit_if.master        imem,
    output logic [31:0]          IF_PC,
    output logic [31:0]          IF_opcplus4,
    output logic [31:0]          IF_instruction,
    output logic                 IF_valid,
    output logic                 pc_misalign
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   skid_q, skid_d;
    logic [XLEN-1:0]   pending_q, pending_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [XLEN-1:0]   if_op4_q, if_op4_d;
    logic [XLEN-1:0]   if_instr_q, if_instr_d;
    logic              if_valid_q, if_valid_d;
    logic              misalign_q, misalign_d;
    logic              req_q, req_d;

    logic              redirect;
    logic [XLEN-1:0]   target_raw;
    logic [XLEN-1:0]   target;
    logic              slot_free;
    logic [XLEN-1:0]   pc_plus4;

    // Redirect source selection, highest priority first
    always_comb begin
        target_raw = branch_target;
        if (exc_req)     target_raw = EXC_VECTOR;
        else if (eret)   target_raw = epc;
        else if (jump)   target_raw = jump_target;
        redirect = exc_req | eret | jump | branch_taken;
        target   = {target_raw[XLEN-1:2], 2'b00};
    end

    assign slot_free = !if_valid_q || PCWrite;
    assign pc_plus4  = pc_q + XLEN'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        pending_d  = pending_q;
        if_pc_d    = if_pc_q;
        if_op4_d   = if_op4_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q && !PCWrite;
        misalign_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) pc_d = target;
            end
            REQ: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        pc_d = target;
                    end else begin
                        pending_d = target;
                        state_d   = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    if (slot_free) begin
                        if_instr_d = imem.imem_rdata;
                        if_pc_d    = pc_q;
                        if_op4_d   = pc_plus4;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus4;
                    end else begin
                        skid_d  = imem.imem_rdata;
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (slot_free) begin
                    if_instr_d = skid_q;
                    if_pc_d    = pc_q;
                    if_op4_d   = pc_plus4;
                    if_valid_d = 1'b1;
                    pc_d       = pc_plus4;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                // Stale response is always discarded; address stays at pc_q until ready
                if (imem.imem_ready) begin
                    pc_d    = redirect ? target : pending_q;
                    state_d = REQ;
                end else if (redirect) begin
                    pending_d = target;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over any consume or capture at the same edge
        if (redirect) begin
            if_valid_d = 1'b0;
            if_pc_d    = '0;
            if_op4_d   = '0;
            if_instr_d = '0;
            misalign_d = (target_raw[1:0] != 2'b00);
        end

        req_d = (state_d == REQ) || (state_d == DRAIN);
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            skid_q     <= '0;
            pending_q  <= '0;
            if_pc_q    <= '0;
            if_op4_q   <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            skid_q     <= skid_d;
            pending_q  <= pending_d;
            if_pc_q    <= if_pc_d;
            if_op4_q   <= if_op4_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            misalign_q <= misalign_d;
            req_q      <= req_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign IF_PC          = if_pc_q;
    assign IF_opcplus4    = if_op4_q;
    assign IF_instruction = if_instr_q;
    assign IF_valid       = if_valid_q;
    assign pc_misalign    = misalign_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, hand-written corner sequences and a
// randomized run checked against an in-order instruction-stream model.
module tb_ifetch_unit;
    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        pcw, rdy, exc, ert, jmp, br;
    logic [31:0] ept, jt, bt;
    logic [31:0] if_pc, if_op4, if_instr;
    logic        if_valid, mis;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_unit_if imem_bus();

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_bus.imem_ready = rdy;
    assign imem_bus.imem_rdata = rdy ? mem(imem_bus.imem_addr) : 32'hDEAD_BEEF;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0008)) dut (
        .cpu_clk(cpu_clk), .reset(reset), .PCWrite(pcw),
        .exc_req(exc), .eret(ert), .epc(ept),
        .jump(jmp), .jump_target(jt),
        .branch_taken(br), .branch_target(bt),
        .imem(imem_bus.master),
        .IF_PC(if_pc), .IF_opcplus4(if_op4), .IF_instruction(if_instr),
        .IF_valid(if_valid), .pc_misalign(mis)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  ctl;      // {pcw, rdy, exc, eret, jump, branch}
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    function automatic vec_t v(input logic [5:0] ctl, input logic [31:0] tgt, input logic rq,
                               input logic [31:0] ad, input logic vl, input logic [31:0] ipc,
                               input logic ms);
        vec_t r;
        r.ctl = ctl; r.tgt = tgt; r.e_req = rq; r.e_addr = ad;
        r.e_valid = vl; r.e_pc = ipc; r.e_mis = ms;
        return r;
    endfunction

    task automatic clear_in();
        pcw = 1'b0; rdy = 1'b0; exc = 1'b0; ert = 1'b0; jmp = 1'b0; br = 1'b0;
        ept = '0; jt = '0; bt = '0;
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        clear_in();
        reset = 1'b1;
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #1 reset = 1'b0;
    endtask

    vec_t tbl[24];

    initial begin
        logic [31:0] e4;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] held_addr;
        logic        red, held;
        int          consumed;

        clear_in();
        reset = 1'b1;
        #1;
        chk("reset_req",   32'(imem_bus.imem_req), 32'd0);
        chk("reset_valid", 32'(if_valid), 32'd0);
        chk("reset_ifpc",  if_pc, 32'd0);
        chk("reset_mis",   32'(mis), 32'd0);

        tbl[0]  = v(6'b110000, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         1'b0);
        tbl[1]  = v(6'b110000, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         1'b0);
        tbl[2]  = v(6'b110000, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4,         1'b0);
        tbl[3]  = v(6'b010000, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         1'b0);
        tbl[4]  = v(6'b010000, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         1'b0);
        tbl[5]  = v(6'b010000, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         1'b0);
        tbl[6]  = v(6'b110000, 32'h0,         1'b1, 32'hC,         1'b1, 32'h8,         1'b0);
        tbl[7]  = v(6'b100000, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0,         1'b0);
        tbl[8]  = v(6'b100001, 32'h100,       1'b1, 32'hC,         1'b0, 32'h0,         1'b0);
        tbl[9]  = v(6'b100000, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0,         1'b0);
        tbl[10] = v(6'b110000, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0,         1'b0);
        tbl[11] = v(6'b110000, 32'h0,         1'b1, 32'h104,       1'b1, 32'h100,       1'b0);
        tbl[12] = v(6'b110010, 32'h103,       1'b1, 32'h100,       1'b0, 32'h0,         1'b1);
        tbl[13] = v(6'b110000, 32'h0,         1'b1, 32'h104,       1'b1, 32'h100,       1'b0);
        tbl[14] = v(6'b100100, 32'h44,        1'b1, 32'h104,       1'b0, 32'h0,         1'b0);
        tbl[15] = v(6'b110000, 32'h0,         1'b1, 32'h44,        1'b0, 32'h0,         1'b0);
        tbl[16] = v(6'b110000, 32'h0,         1'b1, 32'h48,        1'b1, 32'h44,        1'b0);
        tbl[17] = v(6'b111000, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0,         1'b0);
        tbl[18] = v(6'b110010, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0);
        tbl[19] = v(6'b110000, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0);
        tbl[20] = v(6'b110000, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         1'b0);
        tbl[21] = v(6'b010000, 32'h0,         1'b0, 32'h4,         1'b1, 32'h0,         1'b0);
        tbl[22] = v(6'b000001, 32'h200,       1'b1, 32'h200,       1'b0, 32'h0,         1'b0);
        tbl[23] = v(6'b110000, 32'h0,         1'b1, 32'h204,       1'b1, 32'h200,       1'b0);

        @(posedge cpu_clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge cpu_clk);
            {pcw, rdy, exc, ert, jmp, br} = tbl[i].ctl;
            ept = tbl[i].tgt; jt = tbl[i].tgt; bt = tbl[i].tgt;
            @(posedge cpu_clk);
            #1;
            chk($sformatf("row%0d_req", i),   32'(imem_bus.imem_req), 32'(tbl[i].e_req));
            chk($sformatf("row%0d_addr", i),  imem_bus.imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d_mis", i),   32'(mis), 32'(tbl[i].e_mis));
            if (tbl[i].e_valid) begin
                e4 = tbl[i].e_pc + 32'd4;
                chk($sformatf("row%0d_ifpc", i),  if_pc, tbl[i].e_pc);
                chk($sformatf("row%0d_op4", i),   if_op4, e4);
                chk($sformatf("row%0d_instr", i), if_instr, mem(tbl[i].e_pc));
            end
        end

        // Redirect priority with all sources disagreeing
        @(negedge cpu_clk);
        clear_in();
        pcw = 1'b1; rdy = 1'b1;
        exc = 1'b1; jmp = 1'b1; jt = 32'h200; br = 1'b1; bt = 32'h300;
        @(posedge cpu_clk); #1;
        chk("prio_exc", imem_bus.imem_addr, 32'h8);
        @(negedge cpu_clk);
        exc = 1'b0; br = 1'b0; ert = 1'b1; ept = 32'h44;
        @(posedge cpu_clk); #1;
        chk("prio_eret", imem_bus.imem_addr, 32'h44);
        @(negedge cpu_clk);
        ert = 1'b0; br = 1'b1;
        @(posedge cpu_clk); #1;
        chk("prio_jump", imem_bus.imem_addr, 32'h200);

        // Reset asserted while a request is waiting
        @(negedge cpu_clk);
        clear_in();
        pcw = 1'b1;
        @(posedge cpu_clk); #1;
        chk("wait_req", 32'(imem_bus.imem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_req",  32'(imem_bus.imem_req), 32'd0);
        chk("rst_async_addr", imem_bus.imem_addr, 32'd0);
        @(posedge cpu_clk); #1 reset = 1'b0;
        rdy = 1'b1;
        @(posedge cpu_clk); #1;
        chk("restart_req",  32'(imem_bus.imem_req), 32'd1);
        chk("restart_addr", imem_bus.imem_addr, 32'd0);
        @(posedge cpu_clk); #1;
        chk("restart_valid", 32'(if_valid), 32'd1);
        chk("restart_ifpc",  if_pc, 32'd0);

        // Randomized run against an in-order instruction stream model
        do_reset();
        exp_pc   = 32'h0000_0000;
        consumed = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge cpu_clk);
            pcw = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            exc = ($urandom_range(0, 39) == 0);
            ert = ($urandom_range(0, 29) == 0);
            jmp = ($urandom_range(0, 24) == 0);
            br  = ($urandom_range(0, 19) == 0);
            ept = 32'($urandom_range(0, 1023));
            jt  = 32'($urandom_range(0, 1023));
            bt  = 32'($urandom_range(0, 1023));
            if (c % 500 == 7) jt = 32'hFFFF_FFF8;

            red = exc | ert | jmp | br;
            tgt = exc ? 32'h8 : ert ? ept : jmp ? jt : bt;
            held      = imem_bus.imem_req && !rdy;
            held_addr = imem_bus.imem_addr;

            if (!red && pcw && if_valid) begin
                e4 = exp_pc + 32'd4;
                chk("rand_ifpc",  if_pc, exp_pc);
                chk("rand_instr", if_instr, mem(exp_pc));
                chk("rand_op4",   if_op4, e4);
                exp_pc   = e4;
                consumed++;
            end
            if (red) exp_pc = {tgt[31:2], 2'b00};

            @(posedge cpu_clk); #1;
            chk("rand_mis", 32'(mis), 32'(red && (tgt[1:0] != 2'b00)));
            if (red) chk("rand_flush", 32'(if_valid), 32'd0);
            if (held) begin
                chk("rand_hold_req",  32'(imem_bus.imem_req), 32'd1);
                chk("rand_hold_addr", imem_bus.imem_addr, held_addr);
            end
        end
        n_tests++;
        if (consumed < 200) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d consumed expected at least 200", consumed);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
